// File: rtl/uart_rx_monitor_pkg.sv
// uart_rx_monitor_pkg: shared types and constants for the UART receiver.
// Holds FSM state encoding, parity modes and FIFO entry field offsets.
package uart_rx_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // FIFO entry: {frame_err, parity_err, data[db-1:0]}
   function automatic int pe_ofs(input int db);
      return db;
   endfunction

   function automatic int fe_ofs(input int db);
      return db + 1;
   endfunction

   function automatic int entry_w(input int db);
      return db + 2;
   endfunction

endpackage

// File: rtl/uart_rx_monitor_fifo.sv
// uart_rx_monitor_fifo: synchronous first-word-fall-through FIFO.
// Ports: i_wr/i_wdata push, i_rd pop, o_rdata head (0 when empty),
// o_empty, o_full, o_level occupancy. Sync active-high reset rst.
module uart_rx_monitor_fifo
   import uart_rx_monitor_pkg::*;
#(
   parameter int W     = 10,
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_rd,
   output logic [W-1:0]  o_rdata,
   output logic          o_empty,
   output logic          o_full,
   output logic [LW-1:0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [LW-1:0] r_level;
   logic          w_rd;
   logic          w_wr;

   assign o_empty = (r_level == '0);
   assign o_full  = (r_level == LW'(DEPTH));
   assign w_rd    = i_rd && !o_empty;
   // a full FIFO still accepts a write when a pop frees a slot
   assign w_wr    = i_wr && (!o_full || w_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_rd) r_rp <= r_rp + 1'b1;
         unique case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= i_wdata;
   end

   assign o_rdata = o_empty ? '0 : r_mem[r_rp];
   assign o_level = r_level;

endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: UART receiver with 2-flop sync, FSM and output FIFO.
// Ports: rx_i serial in; rx_* FIFO head with valid/ready pop;
// break_o/overrun_o pulses; fifo_level_o occupancy. Sync reset rst.
// Optional macro UART_RX_MONITOR_DISPLAY_EN prints each pushed char.
module uart_rx_monitor
   import uart_rx_monitor_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx_i,
   output logic [DATA_BITS-1:0]        rx_data_o,
   output logic                        rx_frame_err_o,
   output logic                        rx_parity_err_o,
   output logic                        rx_valid_o,
   input  logic                        rx_ready_i,
   output logic                        break_o,
   output logic                        overrun_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   localparam int EW  = entry_w(DATA_BITS);
   localparam int PEO = pe_ofs(DATA_BITS);
   localparam int FEO = fe_ofs(DATA_BITS);
   localparam int LW  = $clog2(FIFO_DEPTH) + 1;
   localparam int CW  = $clog2(CLKS_PER_BIT + 1);
   localparam int BW  = 4;

   localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);

   logic [1:0]           r_sync;
   logic                 r_prev;
   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_pe;
   logic                 r_fe;
   logic                 r_break;
   logic                 r_ovr;

   logic                 w_rx;
   logic                 w_fall;
   logic                 w_tick;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_fe;
   logic                 w_exp_par;
   logic                 w_empty;
   logic                 w_full;
   logic [EW-1:0]        w_wdata;
   logic [EW-1:0]        w_rdata;
   logic [LW-1:0]        w_level;

   assign w_rx   = r_sync[1];
   assign w_fall = r_prev && !w_rx;
   assign w_tick = (r_cnt == CW'(1));

   // stop-bit result including the sample taken this cycle
   assign w_fe   = r_fe || !w_rx;
   assign w_push = (r_state == ST_STOP) && w_tick &&
                   (r_bit == LAST_S);
   assign w_pop  = rx_ready_i && !w_empty;

   assign w_exp_par = (PARITY == PARITY_EVEN) ? (^r_shift)
                                              : ~(^r_shift);
   assign w_wdata   = {w_fe, r_pe, r_shift};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= 2'b11;
         r_prev  <= 1'b1;
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_pe    <= 1'b0;
         r_fe    <= 1'b0;
         r_break <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], rx_i};
         r_prev  <= w_rx;
         r_break <= w_push && w_fe && (r_shift == '0);
         r_ovr   <= w_push && w_full && !w_pop;
         if (r_state != ST_IDLE)
            r_cnt <= w_tick ? C_FULL : r_cnt - 1'b1;
         unique case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_cnt   <= C_HALF;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  if (w_rx) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_DATA;
                     r_bit   <= '0;
                     r_pe    <= 1'b0;
                     r_fe    <= 1'b0;
                  end
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                  if (r_bit == LAST_D) begin
                     r_bit   <= '0;
                     r_state <= (PARITY != PARITY_NONE) ?
                                ST_PARITY : ST_STOP;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_tick) begin
                  r_pe    <= (w_rx != w_exp_par);
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_tick) begin
                  r_fe <= w_fe;
                  if (r_bit == LAST_S) begin
                     r_bit   <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   uart_rx_monitor_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_push),
      .i_wdata (w_wdata),
      .i_rd    (rx_ready_i),
      .o_rdata (w_rdata),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_level (w_level)
   );

   assign rx_data_o       = w_rdata[DATA_BITS-1:0];
   assign rx_parity_err_o = w_rdata[PEO];
   assign rx_frame_err_o  = w_rdata[FEO];
   assign rx_valid_o      = !w_empty;
   assign break_o         = r_break;
   assign overrun_o       = r_ovr;
   assign fifo_level_o    = w_level;

`ifdef UART_RX_MONITOR_DISPLAY_EN
   always @(posedge clk) begin
      if (!rst && w_push) begin
         if (w_fe)
            $write("<FE:%h>", r_shift);
         else if (r_pe)
            $write("<PE:%h>", r_shift);
         else
            $write("%c", r_shift);
      end
   end
`endif

endmodule
